// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: sub-word load/store over a req/ack data bus, load align/extend, misalign and bus-timeout flags.
// Latency: non-memory ops combinational; aligned memory op retires in 3 cycles minimum (IDLE, BUSY, DONE), plus extra BUSY cycles until ack.
// Backpressure: stall_req_o freezes ex_mem and earlier stages from the cycle the op is seen until the cycle it retires (DONE).
//
// Ports:
//   clk, rst                  clock (rising edge) and synchronous active-high reset
//   valid_i, wd_i, wreg_i,    instruction from ex_mem: live flag, destination,
//   wdata_i, aluop_i,         write enable, ALU result, opcode,
//   mem_addr_i, reg2_i        effective address, store data
//   wd_o, wreg_o, wdata_o     result towards mem_wb
//   stall_req_o               pipeline hold request
//   addr_err_o, bus_err_o     1-cycle pulses: misaligned access, bus timeout
//   mem_req_o, mem_we_o,      data bus request, write enable,
//   mem_addr_o, mem_sel_o,    word address, byte lanes,
//   mem_wdata_o               lane-replicated store data
//   mem_ack_i, mem_rdata_i    bus completion and load data (same cycle)
//
// Optional feature: define MEM_LLSC_EN to enable LL/SC with an llbit register.
// Without it, LL/SC opcodes pass straight through as non-memory ops.

module mem_stage_hs #(
  parameter int BIG_ENDIAN = 1,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // Opcode encodings shared with the rest of the core.
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
`ifdef MEM_LLSC_EN
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;
`endif
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  // Last BUSY cycle index before the transfer is abandoned: the request
  // stays up for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Everything about the outstanding transfer, captured in IDLE.
  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [4:0]  wd;
    logic        wreg;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [CNT_W-1:0] cnt_q;

  // ---------------------------------------------------------------------
  // Incoming op decode
  // ---------------------------------------------------------------------
  logic        in_load, in_store, in_half, in_word;
  logic        misalign, mem_op, addr_bad, sc_fail, start;
  logic [1:0]  in_lane;
  logic        in_hw_hi;
  logic [3:0]  in_sel;
  logic [31:0] in_wdata;

  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_half  = 1'b0;
    in_word  = 1'b0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: in_load = 1'b1;
      EXE_LH_OP, EXE_LHU_OP: begin
        in_load = 1'b1;
        in_half = 1'b1;
      end
      EXE_LW_OP: begin
        in_load = 1'b1;
        in_word = 1'b1;
      end
      EXE_SB_OP: in_store = 1'b1;
      EXE_SH_OP: begin
        in_store = 1'b1;
        in_half  = 1'b1;
      end
      EXE_SW_OP: begin
        in_store = 1'b1;
        in_word  = 1'b1;
      end
`ifdef MEM_LLSC_EN
      EXE_LL_OP: begin
        in_load = 1'b1;
        in_word = 1'b1;
      end
      EXE_SC_OP: begin
        in_store = 1'b1;
        in_word  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign misalign = (in_half & mem_addr_i[0]) | (in_word & (|mem_addr_i[1:0]));
  assign mem_op   = valid_i & (in_load | in_store);
  assign addr_bad = mem_op & misalign;

`ifdef MEM_LLSC_EN
  logic llbit_q;
  // SC without a reservation fails locally: no bus cycle, no stall.
  assign sc_fail = mem_op & ~misalign & (aluop_i == EXE_SC_OP) & ~llbit_q;
`else
  assign sc_fail = 1'b0;
`endif

  assign start = mem_op & ~misalign & ~sc_fail;

  // Lane mapping: in big-endian mode byte address 0 lives in lane 3, so the
  // lane index is the inverted address; the halfword at addr[1]=0 is lanes 3:2.
  assign in_lane  = (BIG_ENDIAN != 0) ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
  assign in_hw_hi = (BIG_ENDIAN != 0) ? ~mem_addr_i[1]   : mem_addr_i[1];

  always_comb begin
    in_sel   = 4'b0001 << in_lane;
    in_wdata = {4{reg2_i[7:0]}};
    if (in_word) begin
      in_sel   = 4'b1111;
      in_wdata = reg2_i;
    end else if (in_half) begin
      in_sel   = in_hw_hi ? 4'b1100 : 4'b0011;
      in_wdata = {2{reg2_i[15:0]}};
    end
  end

  // ---------------------------------------------------------------------
  // Load data extraction from the captured bus word
  // ---------------------------------------------------------------------
  logic [1:0]  q_lane;
  logic        q_hw_hi;
  logic [7:0]  q_byte;
  logic [15:0] q_half;
  logic [31:0] load_data;

  assign q_lane  = (BIG_ENDIAN != 0) ? ~req_q.addr[1:0] : req_q.addr[1:0];
  assign q_hw_hi = (BIG_ENDIAN != 0) ? ~req_q.addr[1]   : req_q.addr[1];
  assign q_byte  = rdata_q[{q_lane, 3'b000} +: 8];
  assign q_half  = q_hw_hi ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    case (req_q.op)
      EXE_LB_OP:  load_data = {{24{q_byte[7]}}, q_byte};
      EXE_LBU_OP: load_data = {24'd0, q_byte};
      EXE_LH_OP:  load_data = {{16{q_half[15]}}, q_half};
      EXE_LHU_OP: load_data = {16'd0, q_half};
      default:    load_data = rdata_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  logic timeout_hit;
  assign timeout_hit = (state_q == BUSY) & ~mem_ack_i & (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (mem_ack_i || timeout_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Transfer context, captured data and timeout counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          if (start) begin
            req_q.op    <= aluop_i;
            req_q.addr  <= mem_addr_i;
            req_q.wd    <= wd_i;
            req_q.wreg  <= wreg_i;
            req_q.we    <= in_store;
            req_q.sel   <= in_sel;
            req_q.wdata <= in_wdata;
          end
        end
        BUSY: begin
          // Ack wins over a simultaneous timeout.
          if (mem_ack_i) begin
            rdata_q <= mem_rdata_i;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

`ifdef MEM_LLSC_EN
  // Reservation is set when an LL completes and consumed by any SC that
  // reaches the bus, whether or not that SC itself completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_q <= 1'b0;
    end else if (state_q == DONE) begin
      if (req_q.op == EXE_LL_OP && !err_q) begin
        llbit_q <= 1'b1;
      end else if (req_q.op == EXE_SC_OP) begin
        llbit_q <= 1'b0;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    wd_o        = NOP_REG_ADDR;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    stall_req_o = 1'b0;
    addr_err_o  = 1'b0;
    bus_err_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_sel_o   = 4'd0;
    mem_wdata_o = 32'd0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (addr_bad) begin
            wd_o       = wd_i;
            wdata_o    = wdata_i;
            addr_err_o = 1'b1;
          end else if (sc_fail) begin
            wd_o   = wd_i;
            wreg_o = 1'b1;
          end else if (start) begin
            // Bubble towards mem_wb while the transfer is set up.
            stall_req_o = 1'b1;
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        BUSY: begin
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = req_q.we;
          mem_addr_o  = {req_q.addr[31:2], 2'b00};
          mem_sel_o   = req_q.sel;
          mem_wdata_o = req_q.wdata;
        end
        DONE: begin
          wd_o = req_q.wd;
          if (err_q) begin
            bus_err_o = 1'b1;
          end else if (!req_q.we) begin
            wreg_o  = req_q.wreg;
            wdata_o = load_data;
          end
`ifdef MEM_LLSC_EN
          else if (req_q.op == EXE_SC_OP) begin
            wreg_o  = 1'b1;
            wdata_o = 32'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: scoreboarded retire checks plus bus-side checks.
// Latency: expected stall and request cycle counts are checked per op.
// Backpressure: a bench-side bus model acks after a chosen number of BUSY cycles, or never.

module tb_mem_stage_hs;
  localparam int TIMEOUT = 64;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
`ifdef MEM_LLSC_EN
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        addr_err_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  mem_stage_hs #(.BIG_ENDIAN(1), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
    .addr_err_o(addr_err_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        aerr;
    logic        berr;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i    = 1'b0;
    aluop_i    = OP_NOP;
    wd_i       = 5'd0;
    wreg_i     = 1'b0;
    wdata_i    = 32'd0;
    mem_addr_i = 32'd0;
    reg2_i     = 32'd0;
  endtask

  // Independent reference: big-endian byte k of a word is the k-th byte from the MSB end.
  function automatic logic [31:0] model_lb(input logic [31:0] rdata, input int k, input bit sign);
    logic [7:0] b;
    b = 8'(rdata >> (8 * (3 - k)));
    return sign ? {{24{b[7]}}, b} : {24'd0, b};
  endfunction

  // Drive one op (called at posedge+1), play the bus, and score its retirement.
  // ack_at: BUSY-cycle index (0 = first) on which the bus acks; -1 never acks.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] alu, input int ack_at, input logic [31:0] rdata,
                        input logic e_wreg, input logic [31:0] e_wdata, input logic e_aerr,
                        input logic e_berr, input int e_stalls, input int e_reqs,
                        input logic [3:0] e_sel, input logic [31:0] e_mwdata);
    exp_t e, got;
    int   stalls;
    int   reqs;
    bit   done;
    e.wd = wd; e.wreg = e_wreg; e.wdata = e_wdata; e.aerr = e_aerr; e.berr = e_berr;
    e.stalls = e_stalls; e.reqs = e_reqs;
    sb_q.push_back(e);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = alu;
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        if (reqs == 0) begin
          chk({tag, " mem_addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
          chk({tag, " mem_sel"}, {28'd0, mem_sel_o}, {28'd0, e_sel});
          chk({tag, " mem_we"}, {31'd0, mem_we_o}, {31'd0, op[3]});
          if (op[3]) chk({tag, " mem_wdata"}, mem_wdata_o, e_mwdata);
        end
        mem_ack_i   = (reqs == ack_at);
        mem_rdata_i = rdata;
        reqs++;
      end
      if (!stall_req_o) begin
        got = sb_q.pop_front();
        chk({tag, " wreg"}, {31'd0, wreg_o}, {31'd0, got.wreg});
        if (got.wreg) begin
          chk({tag, " wd"}, {27'd0, wd_o}, {27'd0, got.wd});
          chk({tag, " wdata"}, wdata_o, got.wdata);
        end
        chk({tag, " addr_err"}, {31'd0, addr_err_o}, {31'd0, got.aerr});
        chk({tag, " bus_err"}, {31'd0, bus_err_o}, {31'd0, got.berr});
        chk({tag, " stalls"}, stalls, got.stalls);
        chk({tag, " reqs"}, reqs, got.reqs);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
    end
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL %s retire: observed no retire within budget, expected retire", tag);
      void'(sb_q.pop_front());
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wd_o", {27'd0, wd_o}, 32'd0);
    chk("reset wreg_o", {31'd0, wreg_o}, 32'd0);
    chk("reset wdata_o", wdata_o, 32'd0);
    chk("reset stall", {31'd0, stall_req_o}, 32'd0);
    chk("reset req", {31'd0, mem_req_o}, 32'd0);
    chk("reset errs", {30'd0, addr_err_o, bus_err_o}, 32'd0);
    chk("reset bus", mem_addr_o | mem_wdata_o | {28'd0, mem_sel_o} | {31'd0, mem_we_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory op and an idle slot pass straight through.
    run_op("add", OP_ADD, 32'h100, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF, -1, 32'h0,
           1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 4'h0, 32'h0);
    valid_i = 1'b0; aluop_i = OP_LW; mem_addr_i = 32'h100; wd_i = 5'd3; wreg_i = 1'b1;
    wdata_i = 32'h1234;
    @(negedge clk);
    chk("novalid stall", {31'd0, stall_req_o}, 32'd0);
    chk("novalid wdata", wdata_o, 32'h1234);
    chk("novalid wd", {27'd0, wd_o}, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("novalid req", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();

    // Loads.
    run_op("lw", OP_LW, 32'h100, 32'h0, 5'd8, 1'b1, 32'h0, 0, 32'h11223344,
           1'b1, 32'h11223344, 1'b0, 1'b0, 2, 1, 4'b1111, 32'h0);
    run_op("lb", OP_LB, 32'h103, 32'h0, 5'd9, 1'b1, 32'h0, 0, 32'h112233F4,
           1'b1, 32'hFFFFFFF4, 1'b0, 1'b0, 2, 1, 4'b0001, 32'h0);
    run_op("lbu", OP_LBU, 32'h103, 32'h0, 5'd10, 1'b1, 32'h0, 0, 32'h112233F4,
           1'b1, 32'h000000F4, 1'b0, 1'b0, 2, 1, 4'b0001, 32'h0);
    run_op("lh", OP_LH, 32'h102, 32'h0, 5'd11, 1'b1, 32'h0, 0, 32'h8899AABB,
           1'b1, 32'hFFFFAABB, 1'b0, 1'b0, 2, 1, 4'b0011, 32'h0);
    run_op("lhu", OP_LHU, 32'h100, 32'h0, 5'd12, 1'b1, 32'h0, 0, 32'h8899AABB,
           1'b1, 32'h00008899, 1'b0, 1'b0, 2, 1, 4'b1100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      run_op("lb_lane", OP_LB, 32'h200 + k, 32'h0, 5'd13, 1'b1, 32'h0, 0, 32'h8041C203,
             1'b1, model_lb(32'h8041C203, k, 1'b1), 1'b0, 1'b0, 2, 1, 4'b1000 >> k, 32'h0);
    end
    run_op("lw_slow", OP_LW, 32'h204, 32'h0, 5'd14, 1'b1, 32'h0, 3, 32'hA5A55A5A,
           1'b1, 32'hA5A55A5A, 1'b0, 1'b0, 5, 4, 4'b1111, 32'h0);

    // Stores.
    run_op("sh", OP_SH, 32'h102, 32'h0000ABCD, 5'd0, 1'b0, 32'h0, 0, 32'h0,
           1'b0, 32'h0, 1'b0, 1'b0, 2, 1, 4'b0011, 32'hABCDABCD);
    run_op("sb", OP_SB, 32'h101, 32'h1234565A, 5'd0, 1'b0, 32'h0, 0, 32'h0,
           1'b0, 32'h0, 1'b0, 1'b0, 2, 1, 4'b0100, 32'h5A5A5A5A);
    run_op("sw", OP_SW, 32'h104, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0, 1, 32'h0,
           1'b0, 32'h0, 1'b0, 1'b0, 3, 2, 4'b1111, 32'hCAFEF00D);

    // Misaligned accesses: flagged in the same cycle, never reach the bus.
    run_op("lw_mis", OP_LW, 32'h101, 32'h0, 5'd15, 1'b1, 32'h0, 0, 32'h0,
           1'b0, 32'h0, 1'b1, 1'b0, 0, 0, 4'h0, 32'h0);
    run_op("sh_mis", OP_SH, 32'h103, 32'h0, 5'd0, 1'b0, 32'h0, 0, 32'h0,
           1'b0, 32'h0, 1'b1, 1'b0, 0, 0, 4'h0, 32'h0);
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h101; wd_i = 5'd15; wreg_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lw_mis hold req", {31'd0, mem_req_o}, 32'd0);
      chk("lw_mis hold stall", {31'd0, stall_req_o}, 32'd0);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Timeout: request held TIMEOUT cycles, then a bus error; a late ack is ignored.
    run_op("lw_to", OP_LW, 32'h300, 32'h0, 5'd16, 1'b1, 32'h0, -1, 32'h0,
           1'b0, 32'h0, 1'b0, 1'b1, TIMEOUT + 1, TIMEOUT, 4'b1111, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late ack req", {31'd0, mem_req_o}, 32'd0);
    chk("late ack bus_err", {31'd0, bus_err_o}, 32'd0);
    chk("late ack wreg", {31'd0, wreg_o}, 32'd0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;

    // Reset in the second BUSY cycle.
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h400; wd_i = 5'd17; wreg_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid busy1 req", {31'd0, mem_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mid stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_mid outs", {26'd0, wd_o, wreg_o} | wdata_o, 32'd0);
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("rst_mid late ack", {30'd0, mem_req_o, bus_err_o}, 32'd0);
    @(posedge clk); #1;
    run_op("lw_after_rst", OP_LW, 32'h404, 32'h0, 5'd18, 1'b1, 32'h0, 0, 32'h0BADF00D,
           1'b1, 32'h0BADF00D, 1'b0, 1'b0, 2, 1, 4'b1111, 32'h0);

`ifdef MEM_LLSC_EN
    run_op("ll", OP_LL, 32'h500, 32'h0, 5'd19, 1'b1, 32'h0, 0, 32'h00000055,
           1'b1, 32'h00000055, 1'b0, 1'b0, 2, 1, 4'b1111, 32'h0);
    run_op("sc_ok", OP_SC, 32'h500, 32'h00000077, 5'd20, 1'b1, 32'h0, 0, 32'h0,
           1'b1, 32'h00000001, 1'b0, 1'b0, 2, 1, 4'b1111, 32'h00000077);
    run_op("sc_fail", OP_SC, 32'h500, 32'h00000077, 5'd21, 1'b1, 32'h0, 0, 32'h0,
           1'b1, 32'h00000000, 1'b0, 1'b0, 0, 0, 4'h0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
